// File: rtl/prog_fetch_pkg.sv
// Shared types and defaults for the program-ROM fetch arbiter.
package prog_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 18;
  localparam logic [9:0]  INTR_VEC_DEF = 10'h3FF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/prog_pc.sv
// Program counter: interrupt vector > branch load > increment on granted fetch > hold.
module prog_pc #(
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] INTR_VEC = '1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_intr,
  input  logic              i_ld,
  input  logic [ADDR_W-1:0] i_din,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;

  always_comb begin
    w_pc_nxt = r_pc;
    if (i_intr)
      w_pc_nxt = INTR_VEC;
    else if (i_ld)
      w_pc_nxt = i_din;
    else if (i_inc)
      w_pc_nxt = r_pc + ADDR_W'(1);  // top address wraps to zero
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_pc <= '0;
    else
      r_pc <= w_pc_nxt;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/prog_rom_fetch_arbiter.sv
// Shares the single program-ROM read port between CPU fetch and a debug reader,
// owns the PC, and routes the one-cycle-late ROM data back to the owner.
module prog_rom_fetch_arbiter
  import prog_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       MAX_WAIT = 8,
  parameter logic [ADDR_W-1:0] INTR_VEC = ADDR_W'(INTR_VEC_DEF)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FETCH_EN,
  input  logic              PC_LD,
  input  logic [ADDR_W-1:0] PC_DIN,
  input  logic              INTR,
  output logic              FETCH_STALL,
  output logic [ADDR_W-1:0] PC_COUNT,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_VALID,
  input  logic              DBG_REQ,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic              DBG_GNT,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic              DBG_VALID,
  output logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_IR
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [ADDR_W-1:0] w_pc;
  logic              w_force;
  owner_e            w_grant;

  logic [7:0]        r_wait_cnt;
  owner_e            r_own1;
  logic [ADDR_W-1:0] r_addr1;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_dbg_valid;

  prog_pc #(
    .ADDR_W   (ADDR_W),
    .INTR_VEC (INTR_VEC)
  ) u_pc (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_intr  (INTR),
    .i_ld    (PC_LD),
    .i_din   (PC_DIN),
    .i_inc   (w_grant == OWN_CPU),
    .o_pc    (w_pc)
  );

  always_comb begin
    w_force = DBG_REQ && (r_wait_cnt == WAIT_LIM);
    w_grant = OWN_NONE;
    if (w_force)
      w_grant = OWN_DBG;
    else if (FETCH_EN)
      w_grant = OWN_CPU;
    else if (DBG_REQ)
      w_grant = OWN_DBG;
  end

  always_comb begin
    FETCH_STALL = FETCH_EN && (w_grant != OWN_CPU);
    DBG_GNT     = DBG_REQ && (w_grant == OWN_DBG);
    PROG_ADDR   = (w_grant == OWN_DBG) ? DBG_ADDR : w_pc;
  end

  // Counts denied cycles of a pending debug request; saturates at the force threshold.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_wait_cnt <= '0;
    else if (DBG_REQ && (w_grant != OWN_DBG)) begin
      if (r_wait_cnt != WAIT_LIM)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end else
      r_wait_cnt <= '0;
  end

  // Owner and address travel alongside the ROM's one-cycle read latency.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_own1      <= OWN_NONE;
      r_addr1     <= '0;
      r_ir        <= '0;
      r_ir_pc     <= '0;
      r_ir_valid  <= 1'b0;
      r_dbg_data  <= '0;
      r_dbg_valid <= 1'b0;
    end else begin
      r_own1      <= w_grant;
      r_addr1     <= PROG_ADDR;
      r_ir_valid  <= (r_own1 == OWN_CPU);
      r_dbg_valid <= (r_own1 == OWN_DBG);
      if (r_own1 == OWN_CPU) begin
        r_ir    <= PROG_IR;
        r_ir_pc <= r_addr1;
      end
      if (r_own1 == OWN_DBG)
        r_dbg_data <= PROG_IR;
    end
  end

  assign PC_COUNT  = w_pc;
  assign IR        = r_ir;
  assign IR_PC     = r_ir_pc;
  assign IR_VALID  = r_ir_valid;
  assign DBG_DATA  = r_dbg_data;
  assign DBG_VALID = r_dbg_valid;

endmodule

// File: tb/tb_prog_rom_fetch_arbiter.sv
// Directed plus randomized bench for prog_rom_fetch_arbiter against a transaction-level model.
module tb_prog_rom_fetch_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 18;
  localparam int          MW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          FETCH_EN, PC_LD, INTR, DBG_REQ;
  logic [AW-1:0] PC_DIN, DBG_ADDR;
  logic          FETCH_STALL, IR_VALID, DBG_GNT, DBG_VALID;
  logic [AW-1:0] PC_COUNT, IR_PC, PROG_ADDR;
  logic [DW-1:0] IR, DBG_DATA, PROG_IR;

  always #5 CLK = ~CLK;

  prog_rom_fetch_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW),
    .INTR_VEC (10'h3FF)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .FETCH_EN    (FETCH_EN),
    .PC_LD       (PC_LD),
    .PC_DIN      (PC_DIN),
    .INTR        (INTR),
    .FETCH_STALL (FETCH_STALL),
    .PC_COUNT    (PC_COUNT),
    .IR          (IR),
    .IR_PC       (IR_PC),
    .IR_VALID    (IR_VALID),
    .DBG_REQ     (DBG_REQ),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_GNT     (DBG_GNT),
    .DBG_DATA    (DBG_DATA),
    .DBG_VALID   (DBG_VALID),
    .PROG_ADDR   (PROG_ADDR),
    .PROG_IR     (PROG_IR)
  );

  // Program ROM: synchronous read, contents randomized at start.
  logic [DW-1:0] rom [1024];
  always @(posedge CLK) PROG_IR <= rom[PROG_ADDR];

  typedef struct {
    int            due;
    int            own;   // 1 = CPU, 2 = debug
    logic [AW-1:0] addr;
  } ret_t;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc;
  int            m_pc;
  int            m_wait;
  logic [DW-1:0] m_ir, m_dbg;
  logic [AW-1:0] m_ir_pc;
  ret_t          q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_wait = 0; m_ir = '0; m_dbg = '0; m_ir_pc = '0; cyc = 0;
    q.delete();
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic fe, input logic ld, input logic [AW-1:0] din,
                       input logic it, input logic dq, input logic [AW-1:0] da,
                       output logic gnt_seen);
    bit   force_d, cpu_g, dbg_g, due_cpu, due_dbg;
    ret_t r;
    FETCH_EN = fe; PC_LD = ld; PC_DIN = din; INTR = it; DBG_REQ = dq; DBG_ADDR = da;
    #4;
    force_d = dq && (m_wait >= MW);
    cpu_g   = !force_d && fe;
    dbg_g   = force_d || (!fe && dq);
    gnt_seen = DBG_GNT;
    chk("FETCH_STALL", 32'(FETCH_STALL), 32'(fe && !cpu_g));
    chk("DBG_GNT",     32'(DBG_GNT),     32'(dbg_g));
    chk("PROG_ADDR",   32'(PROG_ADDR),   dbg_g ? 32'(da) : 32'(m_pc));
    chk("PC_COUNT",    32'(PC_COUNT),    32'(m_pc));
    due_cpu = 0; due_dbg = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.own == 1) begin
        due_cpu = 1; m_ir = rom[r.addr]; m_ir_pc = r.addr;
      end else begin
        due_dbg = 1; m_dbg = rom[r.addr];
      end
    end
    chk("IR_VALID",  32'(IR_VALID),  32'(due_cpu));
    chk("DBG_VALID", 32'(DBG_VALID), 32'(due_dbg));
    chk("IR",        32'(IR),        32'(m_ir));
    chk("IR_PC",     32'(IR_PC),     32'(m_ir_pc));
    chk("DBG_DATA",  32'(DBG_DATA),  32'(m_dbg));
    if (cpu_g) q.push_back('{due: cyc + 2, own: 1, addr: AW'(m_pc)});
    else if (dbg_g) q.push_back('{due: cyc + 2, own: 2, addr: da});
    if (dq && !dbg_g) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
    else m_wait = 0;
    if (it) m_pc = 'h3FF;
    else if (ld) m_pc = int'(din);
    else if (cpu_g) m_pc = (m_pc + 1) % 1024;
    @(posedge CLK); #1;
    cyc++;
  endtask

  initial begin
    logic          g;
    int            gnt_idx;
    logic          dq;
    logic [AW-1:0] da;

    foreach (rom[i]) rom[i] = DW'($urandom);
    RESET_N = 1'b0; FETCH_EN = 0; PC_LD = 0; INTR = 0; DBG_REQ = 0;
    PC_DIN = '0; DBG_ADDR = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_PC",        32'(PC_COUNT),  32'd0);
    chk("rst_IR_VALID",  32'(IR_VALID),  32'd0);
    chk("rst_DBG_VALID", 32'(DBG_VALID), 32'd0);
    chk("rst_IR",        32'(IR),        32'd0);
    RESET_N = 1'b1;

    // Four straight fetches from PC 0, then drain.
    repeat (4) cycle(1, 0, '0, 0, 0, '0, g);
    repeat (2) cycle(0, 0, '0, 0, 0, '0, g);
    chk("seq_last_IR_PC", 32'(IR_PC), 32'd3);

    // Wrap at the top of the address space.
    cycle(0, 1, 10'h3FF, 0, 0, '0, g);
    cycle(1, 0, '0, 0, 0, '0, g);
    chk("wrap_pc", 32'(PC_COUNT), 32'd0);
    repeat (2) cycle(0, 0, '0, 0, 0, '0, g);
    chk("wrap_IR_PC", 32'(IR_PC), 32'h3FF);

    // Interrupt and branch with a granted fetch: interrupt wins, old-PC fetch still returns.
    cycle(0, 1, 10'h123, 0, 0, '0, g);
    cycle(1, 1, 10'h040, 1, 0, '0, g);
    chk("intr_pc", 32'(PC_COUNT), 32'h3FF);
    repeat (2) cycle(0, 0, '0, 0, 0, '0, g);
    chk("intr_IR_PC", 32'(IR_PC), 32'h123);

    // Idle debug read.
    cycle(0, 0, '0, 0, 1, 10'h045, g);
    chk("dbg_idle_gnt", 32'(g), 32'd1);
    repeat (2) cycle(0, 0, '0, 0, 0, '0, g);
    chk("dbg_idle_data", 32'(DBG_DATA), 32'(rom[10'h045]));

    // Starvation: CPU fetching every cycle, debug must be forced on the 9th cycle.
    gnt_idx = 0;
    for (int i = 1; i <= MW + 1; i++) begin
      cycle(1, 0, '0, 0, (gnt_idx == 0), 10'h2A5, g);
      if (g && gnt_idx == 0) gnt_idx = i;
    end
    chk("starve_gnt_cycle", 32'(gnt_idx), 32'(MW + 1));
    repeat (3) cycle(0, 0, '0, 0, 0, '0, g);

    // Reset during the cycle after a grant: no return pulse.
    cycle(1, 0, '0, 0, 0, '0, g);
    FETCH_EN = 0;
    RESET_N  = 1'b0;
    #1;
    chk("rstmid_IR_VALID", 32'(IR_VALID), 32'd0);
    chk("rstmid_PC",       32'(PC_COUNT), 32'd0);
    chk("rstmid_IR",       32'(IR),       32'd0);
    chk("rstmid_IR_PC",    32'(IR_PC),    32'd0);
    chk("rstmid_DBG_DATA", 32'(DBG_DATA), 32'd0);
    model_reset();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (3) cycle(0, 0, '0, 0, 0, '0, g);

    // Randomized traffic with held debug requests that may be dropped.
    dq = 0; da = '0;
    for (int i = 0; i < 400; i++) begin
      if (!dq && ($urandom % 4 == 0)) begin
        dq = 1; da = AW'($urandom);
      end else if (dq && ($urandom % 20 == 0)) begin
        dq = 0;
      end
      cycle(($urandom % 4) != 0, ($urandom % 16) == 0, AW'($urandom),
            ($urandom % 32) == 0, dq, da, g);
      if (g) dq = 0;
    end
    repeat (3) cycle(0, 0, '0, 0, 0, '0, g);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
